// File: rtl/dcache_writeback_if.sv
// Bundle of the MEM-stage request/response signals and the block memory port
// seen by the direct-mapped write-back data cache.
interface dcache_writeback_if #(
    parameter int ADDR_WIDTH = 32
);
    // CPU side
    logic [ADDR_WIDTH-1:0] data_address_2DC;
    logic                  read_2DC;
    logic                  write_2DC;
    logic [31:0]           data_write_2DC;
    logic [1:0]            data_write_size_2DC;
    logic                  flush_2DC;
    logic [31:0]           data_read_fDC;
    logic                  data_valid_fDC;
    logic                  flush_done_fDC;

    // Block memory side
    logic [ADDR_WIDTH-1:0] data_address_2DM;
    logic                  dBlkRead;
    logic                  dBlkWrite;
    logic [255:0]          block_write_2DM;
    logic [255:0]          block_read_fDM;
    logic                  block_read_fDM_valid;
    logic                  block_write_fDM_valid;

    // The cache: serves the CPU and drives the block memory port.
    modport slave (
        input  data_address_2DC, read_2DC, write_2DC, data_write_2DC,
               data_write_size_2DC, flush_2DC,
               block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
        output data_read_fDC, data_valid_fDC, flush_done_fDC,
               data_address_2DM, dBlkRead, dBlkWrite, block_write_2DM
    );

    // The environment: CPU pipeline plus block memory.
    modport master (
        output data_address_2DC, read_2DC, write_2DC, data_write_2DC,
               data_write_size_2DC, flush_2DC,
               block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
        input  data_read_fDC, data_valid_fDC, flush_done_fDC,
               data_address_2DM, dBlkRead, dBlkWrite, block_write_2DM
    );
endinterface

// File: rtl/dcache_writeback.sv
// Direct-mapped write-back data cache with 256-bit (8-word) lines.
// Hits complete combinationally in IDLE; misses write back a dirty victim,
// then fill. A flush walks every index, writes back dirty lines and
// invalidates the whole cache.
module dcache_writeback #(
    parameter int INDEX_BITS = 5,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    dcache_writeback_if.slave bus
);
    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 5;

    typedef enum logic [2:0] {
        IDLE,
        WBACK,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB,
        FLUSH_DONE
    } state_t;

    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [INDEX_BITS-1:0] index_t;

    state_t state, next_state;
    index_t scan_idx, scan_next;

    logic [255:0]         data_arr [NUM_LINES];
    tag_t                 tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_bits;
    logic [NUM_LINES-1:0] dirty_bits;

    tag_t        req_tag;
    index_t      req_index;
    logic [2:0]  word_sel;
    logic [1:0]  byte_off;
    logic [2:0]  store_bytes;
    logic        cpu_req;
    logic        hit;
    logic [31:0] cur_word;
    logic [31:0] merged_word;

    // Update strobes from the FSM to the storage processes.
    logic write_hit;
    logic install;
    logic clean_line;
    logic invalidate_all;

    assign req_tag     = bus.data_address_2DC[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_index   = bus.data_address_2DC[INDEX_BITS+4:5];
    assign word_sel    = bus.data_address_2DC[4:2];
    assign byte_off    = bus.data_address_2DC[1:0];
    assign store_bytes = (bus.data_write_size_2DC == 2'd0) ? 3'd4 : {1'b0, bus.data_write_size_2DC};
    assign cpu_req     = bus.read_2DC | bus.write_2DC;
    assign hit         = valid_bits[req_index] && (tag_arr[req_index] == req_tag);

    // Word 0 sits in the top 32 bits of the line, so word w starts at bit 32*(7-w).
    assign cur_word = data_arr[req_index][{~word_sel, 5'b00000} +: 32];

    // Merge the store into the resident word: big-endian, most significant
    // store byte at the addressed byte, bytes past the word end dropped.
    always_comb begin
        logic [2:0] lane_rel;
        logic [2:0] src_byte;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        merged_word = cur_word;
        lane_rel    = '0;
        src_byte    = '0;
        for (int b = 0; b < 4; b++) begin
            lane_rel = 3'(b) - {1'b0, byte_off};
            src_byte = store_bytes - 3'd1 - lane_rel;
            if ((3'(b) >= {1'b0, byte_off}) && (lane_rel < store_bytes)) begin
                merged_word[31 - 8*b -: 8] = bus.data_write_2DC[{src_byte[1:0], 3'b000} +: 8];
            end
        end
    end

    // Next-state, bus outputs and storage strobes.
    always_comb begin
        next_state           = state;
        scan_next            = scan_idx;
        bus.data_read_fDC    = '0;
        bus.data_valid_fDC   = 1'b0;
        bus.flush_done_fDC   = 1'b0;
        bus.data_address_2DM = '0;
        bus.dBlkRead         = 1'b0;
        bus.dBlkWrite        = 1'b0;
        bus.block_write_2DM  = '0;
        write_hit            = 1'b0;
        install              = 1'b0;
        clean_line           = 1'b0;
        invalidate_all       = 1'b0;

        unique case (state)
            IDLE: begin
                scan_next = '0;
                if (cpu_req) begin
                    if (hit) begin
                        bus.data_valid_fDC = 1'b1;
                        bus.data_read_fDC  = cur_word;
                        write_hit          = bus.write_2DC;
                    end else if (valid_bits[req_index] && dirty_bits[req_index]) begin
                        next_state = WBACK;
                    end else begin
                        next_state = FILL;
                    end
                end else if (bus.flush_2DC) begin
                    next_state = FLUSH_SCAN;
                end
            end

            WBACK: begin
                bus.dBlkWrite        = 1'b1;
                bus.data_address_2DM = {tag_arr[req_index], req_index, 5'b00000};
                bus.block_write_2DM  = data_arr[req_index];
                if (bus.block_write_fDM_valid) begin
                    next_state = FILL;
                end
            end

            FILL: begin
                bus.dBlkRead         = 1'b1;
                bus.data_address_2DM = {req_tag, req_index, 5'b00000};
                if (bus.block_read_fDM_valid) begin
                    install    = 1'b1;
                    next_state = IDLE;
                end
            end

            FLUSH_SCAN: begin
                if (valid_bits[scan_idx] && dirty_bits[scan_idx]) begin
                    next_state = FLUSH_WB;
                end else if (scan_idx == '1) begin
                    invalidate_all = 1'b1;
                    next_state     = FLUSH_DONE;
                end else begin
                    scan_next = scan_idx + 1'b1;
                end
            end

            FLUSH_WB: begin
                bus.dBlkWrite        = 1'b1;
                bus.data_address_2DM = {tag_arr[scan_idx], scan_idx, 5'b00000};
                bus.block_write_2DM  = data_arr[scan_idx];
                if (bus.block_write_fDM_valid) begin
                    clean_line = 1'b1;
                    if (scan_idx == '1) begin
                        invalidate_all = 1'b1;
                        next_state     = FLUSH_DONE;
                    end else begin
                        scan_next  = scan_idx + 1'b1;
                        next_state = FLUSH_SCAN;
                    end
                end
            end

            FLUSH_DONE: begin
                bus.flush_done_fDC = 1'b1;
                next_state         = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end

    // State, scan pointer and per-line valid/dirty bits.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state      <= IDLE;
            scan_idx   <= '0;
            valid_bits <= '0;
            dirty_bits <= '0;
        end else begin
            state    <= next_state;
            scan_idx <= scan_next;
            if (invalidate_all) begin
                valid_bits <= '0;
                dirty_bits <= '0;
            end else begin
                if (install) begin
                    valid_bits[req_index] <= 1'b1;
                    dirty_bits[req_index] <= 1'b0;
                end
                if (write_hit) begin
                    dirty_bits[req_index] <= 1'b1;
                end
                if (clean_line) begin
                    dirty_bits[scan_idx] <= 1'b0;
                end
            end
        end
    end

    // Line data and tags: filled from memory on install, patched on store hits.
    always_ff @(posedge CLK) begin
        // NOTE: data and tag arrays carry no reset; valid bits gate every use of them.
        if (install) begin
            data_arr[req_index] <= bus.block_read_fDM;
            tag_arr[req_index]  <= req_tag;
        end else if (write_hit) begin
            data_arr[req_index][{~word_sel, 5'b00000} +: 32] <= merged_word;
        end
    end
endmodule

// File: tb/tb_dcache_writeback.sv
// Self-checking bench for dcache_writeback: a memory responder with random
// latency, a per-cycle compare process against a CPU-visible memory image
// plus line-residency model, directed scenarios and a randomized run.
module tb_dcache_writeback;
    localparam int IB = 5;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    dcache_writeback_if #(.ADDR_WIDTH(32)) bus ();

    dcache_writeback #(.INDEX_BITS(IB), .ADDR_WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Physical memory contents and the values the CPU must observe.
    logic [255:0] dram   [bit [31:0]];
    logic [255:0] golden [bit [31:0]];

    // Which block each index holds, and whether it is modified.
    bit   [31:0] res_valid;
    bit   [31:0] res_dirty;
    logic [31:0] res_blk [32];

    logic        cur_req  = 1'b0;
    logic        cur_wr   = 1'b0;
    logic [31:0] cur_addr = '0;
    bit          started  = 1'b0;

    int          wb_count       = 0;
    int          done_count     = 0;
    logic [31:0] last_wb_addr   = '0;
    logic [31:0] last_fill_addr = '0;
    int          fixed_lat      = -1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] blk);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[255 - 32*w -: 32] = ((blk + 32'(4*w)) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] blk);
        return dram.exists(blk) ? dram[blk] : init_line(blk);
    endfunction

    function automatic logic [255:0] golden_line(input logic [31:0] blk);
        return golden.exists(blk) ? golden[blk] : mem_line(blk);
    endfunction

    function automatic logic [31:0] get_word(input logic [255:0] line, input int w);
        return line[255 - 32*w -: 32];
    endfunction

    // Bytes off..off+n-1 get the low n data bytes, most significant first.
    function automatic logic [31:0] store_word(input logic [31:0] old, input int off, input int n,
                                               input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < n; k++) begin
            if (off + k < 4) r[31 - 8*(off + k) -: 8] = d[8*(n - 1 - k) +: 8];
        end
        return r;
    endfunction

    // Block memory responder: random (or pinned) extra wait before each accept.
    initial begin
        int wait_cnt;
        wait_cnt = -1;
        bus.block_read_fDM        = '0;
        bus.block_read_fDM_valid  = 1'b0;
        bus.block_write_fDM_valid = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.block_read_fDM_valid  = 1'b0;
            bus.block_write_fDM_valid = 1'b0;
            if (RESET) begin
                wait_cnt = -1;
            end else if (bus.dBlkRead || bus.dBlkWrite) begin
                if (wait_cnt < 0) wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    if (bus.dBlkWrite) begin
                        dram[bus.data_address_2DM] = bus.block_write_2DM;
                        bus.block_write_fDM_valid  = 1'b1;
                    end else begin
                        bus.block_read_fDM       = mem_line(bus.data_address_2DM);
                        bus.block_read_fDM_valid = 1'b1;
                    end
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    initial begin
        logic [31:0]  cb;
        logic [31:0]  a;
        logic [255:0] line;
        int           ci;
        int           wi;
        int           vi;
        logic         exp_v;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                res_valid = '0;
                res_dirty = '0;
                golden.delete();
            end else if (started) begin
                cb    = {cur_addr[31:5], 5'b00000};
                ci    = int'(cur_addr[9:5]);
                wi    = int'(cur_addr[4:2]);
                exp_v = cur_req && res_valid[ci] && (res_blk[ci] == cb);
                check("data_valid", bus.data_valid_fDC, exp_v);
                if (bus.data_valid_fDC && exp_v) begin
                    line = golden_line(cb);
                    check("data_read", bus.data_read_fDC, get_word(line, wi));
                    if (cur_wr) begin
                        line[255 - 32*wi -: 32] = store_word(get_word(line, wi), int'(cur_addr[1:0]),
                            (bus.data_write_size_2DC == 2'd0) ? 4 : int'(bus.data_write_size_2DC),
                            bus.data_write_2DC);
                        golden[cb]    = line;
                        res_dirty[ci] = 1'b1;
                    end
                end
                check("req_exclusive", bus.dBlkRead & bus.dBlkWrite, 1'b0);
                if (bus.dBlkWrite) begin
                    a  = bus.data_address_2DM;
                    vi = int'(a[9:5]);
                    check("wb_victim", res_valid[vi] && res_dirty[vi] && (res_blk[vi] == a), 1'b1);
                    check("wb_data", bus.block_write_2DM, golden_line(a));
                    if (cur_req) check("wb_index", vi, ci);
                    if (bus.block_write_fDM_valid) begin
                        res_dirty[vi] = 1'b0;
                        wb_count++;
                        last_wb_addr = a;
                    end
                end
                if (bus.dBlkRead) begin
                    check("fill_addr", bus.data_address_2DM, cur_req ? cb : 32'hFFFF_FFFF);
                    if (bus.block_read_fDM_valid) begin
                        check("fill_no_dirty_loss", res_valid[ci] && res_dirty[ci], 1'b0);
                        res_valid[ci] = 1'b1;
                        res_dirty[ci] = 1'b0;
                        res_blk[ci]   = cb;
                        last_fill_addr = bus.data_address_2DM;
                    end
                end
                if (bus.flush_done_fDC) begin
                    check("flush_all_clean", res_dirty, 32'h0);
                    res_valid = '0;
                    done_count++;
                end
            end
        end
    end

    // Issue one CPU access and hold it until data_valid_fDC.
    task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] d, input logic [1:0] sz,
                          output logic [31:0] rdata, output int waits);
        bus.data_address_2DC    = a;
        bus.read_2DC            = rd;
        bus.write_2DC           = wr;
        bus.data_write_2DC      = d;
        bus.data_write_size_2DC = sz;
        cur_addr = a;
        cur_wr   = wr;
        cur_req  = rd | wr;
        waits    = 0;
        rdata    = '0;
        forever begin
            @(negedge CLK);
            if (bus.data_valid_fDC) begin
                rdata = bus.data_read_fDC;
                break;
            end
            waits++;
            if (waits > 100) begin
                check("access_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus.read_2DC  = 1'b0;
        bus.write_2DC = 1'b0;
        cur_req       = 1'b0;
    endtask

    // Pulse flush for one sampling edge and count cycles until flush_done_fDC.
    task automatic do_flush(output int cycles);
        bus.flush_2DC = 1'b1;
        @(posedge CLK);
        #1;
        bus.flush_2DC = 1'b0;
        cycles = 0;
        forever begin
            @(negedge CLK);
            cycles++;
            if (bus.flush_done_fDC) break;
            if (cycles > 500) begin
                check("flush_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          waits;
        int          cyc;
        int          wb0;
        int          dn0;
        int          kind;

        bus.data_address_2DC    = '0;
        bus.read_2DC            = 1'b0;
        bus.write_2DC           = 1'b0;
        bus.data_write_2DC      = '0;
        bus.data_write_size_2DC = '0;
        bus.flush_2DC           = 1'b0;

        // Outputs while reset is held.
        @(posedge CLK);
        #1;
        check("rst_data_valid", bus.data_valid_fDC, 1'b0);
        check("rst_flush_done", bus.flush_done_fDC, 1'b0);
        check("rst_dBlkRead", bus.dBlkRead, 1'b0);
        check("rst_dBlkWrite", bus.dBlkWrite, 1'b0);
        check("rst_addr_2DM", bus.data_address_2DM, 32'h0);
        check("rst_data_read", bus.data_read_fDC, 32'h0);
        check("rst_block_write", bus.block_write_2DM, 256'h0);
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        started = 1'b1;

        // Cold read miss with three memory cycles, then a zero-wait hit.
        fixed_lat = 2;
        access(32'h1000, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t1_miss_waits", waits, 4);
        check("t1_fill_addr", last_fill_addr, 32'h1000);
        fixed_lat = -1;
        access(32'h1000, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t1_hit_waits", waits, 0);

        // Single-byte store into a known word.
        access(32'h1000, 1'b0, 1'b1, 32'h1122_3344, 2'd0, rd, waits);
        access(32'h1001, 1'b0, 1'b1, 32'h0000_00AB, 2'd1, rd, waits);
        access(32'h1000, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t2_byte_store", rd, 32'h11AB_3344);

        // Conflict miss on a dirty line: write-back then fill.
        access(32'h1400, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t3_wb_addr", last_wb_addr, 32'h1000);
        check("t3_fill_addr", last_fill_addr, 32'h1400);

        // Three-byte store at the last byte of a word stays in that word.
        access(32'h2000, 1'b0, 1'b1, 32'h0102_0304, 2'd0, rd, waits);
        access(32'h2004, 1'b0, 1'b1, 32'h0506_0708, 2'd0, rd, waits);
        access(32'h2003, 1'b0, 1'b1, 32'h005A_3C5A, 2'd3, rd, waits);
        access(32'h2000, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t4_word_2000", rd, 32'h0102_035A);
        access(32'h2004, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t4_word_2004", rd, 32'h0506_0708);

        // Flush with exactly two dirty lines.
        do_flush(cyc);
        access(32'h4000, 1'b0, 1'b1, 32'hCAFE_0001, 2'd0, rd, waits);
        access(32'h4020, 1'b0, 1'b1, 32'hCAFE_0002, 2'd0, rd, waits);
        wb0 = wb_count;
        dn0 = done_count;
        do_flush(cyc);
        repeat (2) @(posedge CLK);
        #1;
        check("t5_wb_count", wb_count - wb0, 2);
        check("t5_done_pulses", done_count - dn0, 1);
        access(32'h4000, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t5_miss_4000", waits > 0, 1'b1);
        check("t5_data_4000", rd, 32'hCAFE_0001);
        access(32'h4020, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t5_miss_4020", waits > 0, 1'b1);

        // Flush of a cache holding only clean lines.
        wb0 = wb_count;
        do_flush(cyc);
        check("clean_flush_cycles", cyc, (1 << IB) + 1);
        check("clean_flush_no_wb", wb_count - wb0, 0);

        // Reset in the middle of a fill.
        fixed_lat = 6;
        bus.data_address_2DC = 32'h3000;
        bus.read_2DC         = 1'b1;
        cur_addr = 32'h3000;
        cur_wr   = 1'b0;
        cur_req  = 1'b1;
        waits    = 0;
        do begin
            @(negedge CLK);
            waits++;
        end while (!bus.dBlkRead && waits < 10);
        check("t6_fill_started", bus.dBlkRead, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        check("t6_dBlkRead_drop", bus.dBlkRead, 1'b0);
        check("t6_addr_drop", bus.data_address_2DM, 32'h0);
        bus.read_2DC = 1'b0;
        cur_req      = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET     = 1'b0;
        fixed_lat = -1;
        access(32'h3000, 1'b1, 1'b0, 32'h0, 2'd0, rd, waits);
        check("t6_miss_again", waits > 0, 1'b1);

        // Randomized mix over a few conflicting blocks.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush(cyc);
            end else begin
                a = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 10)
                  + (32'($urandom_range(0, 3)) << 5) + 32'($urandom_range(0, 31));
                kind = int'($urandom_range(0, 3));
                access(a, kind != 2, kind >= 2, $urandom, 2'($urandom_range(0, 3)), rd, waits);
            end
        end
        do_flush(cyc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
